alu_mc: RTL



---
 rtl/alu_mc.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Shifts iterate one bit per cycle; branch-compare flags are registered at accept.
module alu_mc #(
  parameter int WIDTH    = 32,
  parameter int SH_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Lt,
  output logic             Ltu
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [WIDTH-1:0]    work;
  logic [WIDTH-1:0]    step_val;
  logic [WIDTH-1:0]    comb_res;
  logic [SH_WIDTH-1:0] cnt;
  logic [SH_WIDTH-1:0] shamt;
  logic [1:0]          dir;
  logic                accept;
  logic                is_shift;
  logic                long_op;
  logic                last;

  assign shamt     = SrcB[SH_WIDTH-1:0];
  assign is_shift  = (ALUctrl == 4'b1000) ||
                     (ALUctrl == 4'b1001) ||
                     (ALUctrl == 4'b1010);
  assign long_op   = is_shift && (shamt != '0);
  assign last      = (cnt == SH_WIDTH'(1));
  assign in_ready  = !rst && ((state == IDLE) ||
                     ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // single-cycle result; a zero-distance shift is just SrcA
  always_comb begin
    comb_res = '0;
    case (ALUctrl)
      4'b0000: comb_res = SrcA + SrcB;
      4'b0001: comb_res = SrcA - SrcB;
      4'b0010: comb_res = SrcA ^ SrcB;
      4'b0011: comb_res = SrcA & SrcB;
      4'b0100: comb_res = SrcA | SrcB;
      4'b0101: comb_res = SrcB;
      4'b0110: comb_res = {{(WIDTH-1){1'b0}},
                           $signed(SrcA) < $signed(SrcB)};
      4'b0111: comb_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      4'b1000: comb_res = SrcA;
      4'b1001: comb_res = SrcA;
      4'b1010: comb_res = SrcA;
      default: comb_res = '0;
    endcase
  end

  // one-bit shift of the working register in the captured direction
  always_comb begin
    step_val = work;
    unique case (1'b1)
      (dir == 2'd0): step_val = work << 1;
      (dir == 2'd1): step_val = work >> 1;
      default:       step_val = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  // next-state: accept takes priority, DONE drains on out_ready
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = long_op ? SHIFT : DONE;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (accept)         state_d = long_op ? SHIFT : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // datapath: capture at accept, iterate while shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResult <= '0;
      Zero      <= 1'b0;
      Lt        <= 1'b0;
      Ltu       <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      dir       <= 2'd0;
    end else if (accept) begin
      Zero <= (SrcA == SrcB);
      Lt   <= ($signed(SrcA) < $signed(SrcB));
      Ltu  <= (SrcA < SrcB);
      if (long_op) begin
        work <= SrcA;
        cnt  <= shamt;
        dir  <= ALUctrl[1:0];
      end else begin
        ALUResult <= comb_res;
      end
    end else if (state == SHIFT) begin
      if (last) begin
        ALUResult <= step_val;
        cnt       <= '0;
      end else begin
        work <= step_val;
        cnt  <= cnt - SH_WIDTH'(1);
      end
    end
  end

endmodule
